// File: rtl/aes128_host_ctrl_pkg.sv
// Shared types and constants for the AES-128 host-side controller.
// Holds the command opcode and FSM state enums, the block geometry, and the
// rule that decides whether an incoming command is rejected.
package aes_ctrl_pkg;

  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

  typedef enum logic [1:0] {
    LOAD_KEY = 2'b00,
    ENC      = 2'b01,
    DEC      = 2'b10,
    RSVD     = 2'b11
  } aes_op_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    DRAIN     = 3'd4
  } state_t;

  // A command is refused if the opcode is reserved, or if it needs a key
  // (encrypt/decrypt) and none has been loaded since reset.
  function automatic logic op_rejected(aes_op_t op, logic key_loaded);
    return (op == RSVD) || (((op == ENC) || (op == DEC)) && !key_loaded);
  endfunction

endpackage

// File: rtl/aes128_host_ctrl_if.sv
// Host-side handshake bundle for aes128_host_ctrl: command channel, input
// word stream and result word stream. Signal suffixes are from the
// controller's point of view; "slave" is the controller, "master" the host.
interface aes128_host_ctrl_if;

  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i;

  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_data_i;

  logic        m_valid_o;
  logic        m_ready_i;
  logic [31:0] m_data_o;
  logic        m_last_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, s_valid_i, s_data_i, m_ready_i,
    output cmd_ready_o, s_ready_o, m_valid_o, m_data_o, m_last_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, s_valid_i, s_data_i, m_ready_i,
    input  cmd_ready_o, s_ready_o, m_valid_o, m_data_o, m_last_o
  );

endinterface

// File: rtl/aes128_host_ctrl.sv
// Initiator-side front end for the AES-128 core.
// Takes an opcode plus four big-endian 32-bit words, issues a single
// load-key / start-encrypt / start-decrypt pulse to the core, captures the
// result on the core's done cycle and streams it back as four words.
// Optional build macro AES_CTRL_TIMEOUT_EN: abort WAIT_DONE after
// TIMEOUT_CYCLES cycles without a done pulse (err_o pulse, back to IDLE).
module aes128_host_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  aes128_host_ctrl_if.slave  host,
  output logic               busy_o,
  output logic               err_o,
  output logic               key_loaded_o,
  output logic               aes_load_key_o,
  output logic               aes_start_enc_o,
  output logic               aes_start_dec_o,
  output logic [BLOCK_W-1:0] aes_data_o,
  input  logic [BLOCK_W-1:0] aes_data_i,
  input  logic               aes_ready_i,
  input  logic               aes_done_i
);

  state_t                                 state_q, state_d;
  aes_op_t                                op_q, op_d;
  logic [1:0]                             cnt_q, cnt_d;
  // Element 3 is bits [127:96], so word n of the stream lands in element 3-n.
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] buf_q, buf_d;
  logic                                   key_loaded_q, key_loaded_d;
  logic                                   err_q, err_d;

  aes_op_t cmd_op;
  logic    issue_fire;

  assign cmd_op     = aes_op_t'(host.cmd_op_i);
  assign issue_fire = (state_q == ISSUE) && aes_ready_i;

`ifdef AES_CTRL_TIMEOUT_EN
  localparam int unsigned         TMO_W    = ($clog2(TIMEOUT_CYCLES) > 8) ?
                                             $clog2(TIMEOUT_CYCLES) : 8;
  // Expiry is taken on the cycle whose increment would reach TIMEOUT_CYCLES,
  // so the error pulse appears exactly TIMEOUT_CYCLES cycles after entry.
  localparam logic [TMO_W-1:0]    TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expired;

  assign tmo_expired = (tmo_q == TMO_LAST);

  // Wait counter: zero outside WAIT_DONE, counts every cycle inside it.
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_DONE) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  // TIMEOUT_CYCLES only sizes the wait counter, which this build omits.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  // Next-state, pack buffer, word counter and error/key bookkeeping.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    key_loaded_d = key_loaded_q;
    err_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (host.cmd_valid_i) begin
          op_d = cmd_op;
          if (op_rejected(cmd_op, key_loaded_q)) begin
            err_d = 1'b1;
          end else begin
            state_d = COLLECT;
            cnt_d   = '0;
          end
        end
      end

      COLLECT: begin
        if (host.s_valid_i) begin
          buf_d[~cnt_q] = host.s_data_i;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (aes_ready_i) begin
          if (op_q == LOAD_KEY) begin
            key_loaded_d = 1'b1;
            state_d      = IDLE;
          end else begin
            state_d = WAIT_DONE;
          end
        end
      end

      WAIT_DONE: begin
        // A done pulse beats a simultaneous timeout: the result is kept.
        if (aes_done_i) begin
          buf_d   = aes_data_i;
          cnt_d   = '0;
          state_d = DRAIN;
        end
`ifdef AES_CTRL_TIMEOUT_EN
        else if (tmo_expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
`endif
      end

      DRAIN: begin
        if (host.m_ready_i) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and buffer registers, all cleared by the shared async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= LOAD_KEY;
      cnt_q        <= '0;
      buf_q        <= '0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
    end
  end

  // cmd_ready is masked by rst_n so every output reads zero while in reset.
  assign host.cmd_ready_o = rst_n && (state_q == IDLE);
  assign host.s_ready_o   = (state_q == COLLECT);
  assign host.m_valid_o   = (state_q == DRAIN);
  assign host.m_data_o    = (state_q == DRAIN) ? buf_q[~cnt_q] : '0;
  assign host.m_last_o    = (state_q == DRAIN) && (cnt_q == 2'd3);

  assign busy_o       = (state_q != IDLE);
  assign err_o        = err_q;
  assign key_loaded_o = key_loaded_q;

  // Core strobes are decoded from the ISSUE state, so each lasts one cycle.
  assign aes_load_key_o  = issue_fire && (op_q == LOAD_KEY);
  assign aes_start_enc_o = issue_fire && (op_q == ENC);
  assign aes_start_dec_o = issue_fire && (op_q == DEC);
  assign aes_data_o      = buf_q;

endmodule

// File: tb/tb_aes128_host_ctrl.sv
// Bench for aes128_host_ctrl with a behavioural AES core stand-in.
// The core model returns the FIPS-197 vectors for the reference key and an
// invertible toy cipher otherwise; the controller is checked against a
// transaction-level model (key state, expected word queue, strobe counts).
`timescale 1ns/1ps
module tb_aes128_host_ctrl;
  import aes_ctrl_pkg::*;

  localparam int unsigned TMO = 8;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] TOY_MASK = 128'h5a5a_a5a5_3c3c_c3c3_0f0f_f0f0_9696_6969;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes128_host_ctrl_if hif();

  logic         busy_o, err_o, key_loaded_o;
  logic         aes_load_key_o, aes_start_enc_o, aes_start_dec_o;
  logic [127:0] aes_data_o, aes_data_i;
  logic         aes_ready_i, aes_done_i;

  aes128_host_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host           (hif),
    .busy_o         (busy_o),
    .err_o          (err_o),
    .key_loaded_o   (key_loaded_o),
    .aes_load_key_o (aes_load_key_o),
    .aes_start_enc_o(aes_start_enc_o),
    .aes_start_dec_o(aes_start_dec_o),
    .aes_data_o     (aes_data_o),
    .aes_data_i     (aes_data_i),
    .aes_ready_i    (aes_ready_i),
    .aes_done_i     (aes_done_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic finish_now();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // ---------------- behavioural core ----------------
  function automatic logic [127:0] core_cipher(input logic enc, input logic [127:0] k,
                                               input logic [127:0] d);
    logic [127:0] x;
    if (k == FIPS_KEY && enc && d == FIPS_PT) return FIPS_CT;
    if (k == FIPS_KEY && !enc && d == FIPS_CT) return FIPS_PT;
    if (enc) begin
      x = d ^ k;
      return {x[114:0], x[127:115]} ^ TOY_MASK;
    end
    x = d ^ TOY_MASK;
    return {x[12:0], x[127:13]} ^ k;
  endfunction

  logic [127:0] core_key, core_res;
  int           core_cnt;
  int           core_lat = 1;
  int           lat_fixed = -1;
  logic         core_busy, core_done;
  logic         core_mute = 1'b0;
  logic         stall = 1'b0;
  bit           stall_en = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_key <= '0; core_res <= '0; core_cnt <= 0; core_busy <= 1'b0; core_done <= 1'b0;
    end else begin
      core_done <= 1'b0;
      if (aes_load_key_o) core_key <= aes_data_o;
      if (aes_start_enc_o || aes_start_dec_o) begin
        core_res <= core_cipher(aes_start_enc_o, core_key, aes_data_o);
        if (core_lat == 0) core_done <= !core_mute;
        else begin
          core_busy <= 1'b1;
          core_cnt  <= core_lat - 1;
        end
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          core_busy <= 1'b0;
          core_done <= !core_mute;
        end else core_cnt <= core_cnt - 1;
      end
    end
  end

  assign aes_ready_i = !core_busy && !core_done && !stall;
  assign aes_done_i  = core_done;
  assign aes_data_i  = core_done ? core_res : 128'hdead_beef_dead_beef_dead_beef_dead_beef;

  initial begin
    forever begin
      @(posedge clk); #1;
      stall = stall_en ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
  end

  // ---------------- result sink ----------------
  bit bp_mode = 0;
  int bp_cnt = 0;
  initial begin
    hif.m_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) begin
        if (hif.m_valid_o && bp_cnt < 5) begin
          hif.m_ready_i = 1'b0;
          bp_cnt++;
        end else begin
          hif.m_ready_i = hif.m_valid_o;
          bp_cnt = 0;
        end
      end else hif.m_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- transaction model + monitor ----------------
  logic [32:0]  exp_q[$];
  logic [127:0] exp_block;
  logic [1:0]   exp_op;
  bit           key_m = 0;
  logic [127:0] key_val_m;
  int n_err = 0, n_sready = 0, n_load = 0, n_enc = 0, n_dec = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  bit           hold_prev = 0;
  logic [32:0]  hold_data;
  bit           in_wait = 0;
  logic [127:0] held_block;
`ifdef AES_CTRL_TIMEOUT_EN
  int start_cyc = 0, err_cyc = 0;
`endif

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      hold_prev = 0;
      in_wait   = 0;
    end else begin
      if (err_o) begin
        n_err++;
`ifdef AES_CTRL_TIMEOUT_EN
        err_cyc = cyc;
`endif
      end
      if (hif.s_ready_o) n_sready++;
      if (aes_load_key_o) begin
        n_load++;
        chk("load_data", aes_data_o, exp_block);
      end
      if (aes_start_enc_o || aes_start_dec_o) begin
        if (aes_start_enc_o) n_enc++;
        if (aes_start_dec_o) n_dec++;
`ifdef AES_CTRL_TIMEOUT_EN
        start_cyc = cyc;
`endif
        chk("start_data", aes_data_o, exp_block);
        chk("start_kind", {aes_start_enc_o, aes_start_dec_o}, (exp_op == 2'b01) ? 2'b10 : 2'b01);
        held_block = aes_data_o;
        in_wait    = 1;
      end else if (in_wait) begin
        chk("data_held", aes_data_o, held_block);
        if (aes_done_i || !busy_o) in_wait = 0;
      end
      if (hif.m_valid_o) begin
        chk("m_expected", exp_q.size() != 0, 1'b1);
        if (hold_prev) chk("m_stable", {hif.m_last_o, hif.m_data_o}, hold_data);
        if (hif.m_ready_i) begin
          hold_prev = 0;
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("m_data", hif.m_data_o, e[31:0]);
            chk("m_last", hif.m_last_o, e[32]);
          end
        end else begin
          hold_prev = 1;
          hold_data = {hif.m_last_o, hif.m_data_o};
        end
      end else hold_prev = 0;
    end
  end

  // ---------------- drivers ----------------
  bit gaps_en = 0;

  task automatic send_cmd(input logic [1:0] op);
    bit acc = 0;
    @(posedge clk); #1;
    hif.cmd_valid_i = 1'b1;
    hif.cmd_op_i    = op;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = hif.cmd_ready_o;
      @(posedge clk); #1;
    end
    hif.cmd_valid_i = 1'b0;
    if (!acc) begin
      fail("cmd_accept");
      finish_now();
    end
  endtask

  task automatic send_block(input logic [127:0] blk);
    bit acc;
    for (int w = 0; w < 4; w++) begin
      int gap = gaps_en ? int'($urandom_range(0, 2)) : 0;
      repeat (gap) begin
        hif.s_valid_i = 1'b0;
        hif.s_data_i  = $urandom;
        @(posedge clk); #1;
      end
      hif.s_valid_i = 1'b1;
      hif.s_data_i  = blk[127-32*w -: 32];
      acc = 0;
      for (int i = 0; i < 50 && !acc; i++) begin
        @(negedge clk);
        acc = hif.s_ready_o;
        @(posedge clk); #1;
      end
      if (!acc) begin
        fail("word_accept");
        finish_now();
      end
    end
    hif.s_valid_i = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [127:0] blk,
                        input logic [127:0] lit_res, input bit use_lit);
    int e0 = n_err, s0 = n_sready, l0 = n_load, en0 = n_enc, d0 = n_dec;
    bit rej = (op == 2'b11) || (op != 2'b00 && !key_m);
    bit ok = 0;
    logic [127:0] res;
    core_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 5));
    exp_block = blk;
    exp_op    = op;
    send_cmd(op);
    if (rej) begin
      repeat (3) @(posedge clk);
      #1;
      chk("err_pulses", n_err - e0, 1);
      chk("sready_on_err", n_sready - s0, 0);
      chk("busy_after_err", busy_o, 1'b0);
      return;
    end
    if (op != 2'b00) begin
      res = use_lit ? lit_res : core_cipher(op == 2'b01, key_val_m, blk);
      for (int w = 0; w < 4; w++) exp_q.push_back({w == 3, res[127-32*w -: 32]});
    end
    send_block(blk);
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = !busy_o && (exp_q.size() == 0);
    end
    if (!ok) begin
      fail("op_complete");
      finish_now();
    end
    chk("load_pulses", n_load - l0, (op == 2'b00) ? 1 : 0);
    chk("enc_pulses", n_enc - en0, (op == 2'b01) ? 1 : 0);
    chk("dec_pulses", n_dec - d0, (op == 2'b10) ? 1 : 0);
    chk("no_err", n_err - e0, 0);
    if (op == 2'b00) begin
      key_m     = 1;
      key_val_m = blk;
    end
    chk("key_loaded", key_loaded_o, key_m);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ctl"}, {hif.cmd_ready_o, hif.s_ready_o, hif.m_valid_o, hif.m_data_o,
                          hif.m_last_o, busy_o, err_o, aes_load_key_o, aes_start_enc_o,
                          aes_start_dec_o}, '0);
    chk({name, "_data"}, aes_data_o, '0);
    chk({name, "_key"}, key_loaded_o, 1'b0);
  endtask

  initial begin
    #2_000_000;
    fail("watchdog");
    finish_now();
  end

  initial begin
    logic [127:0] rblk;
    logic [1:0]   rop;
    int           l0;
    bit           ok;
`ifdef AES_CTRL_TIMEOUT_EN
    int           e0;
`endif
    hif.cmd_valid_i = 1'b0;
    hif.cmd_op_i    = 2'b00;
    hif.s_valid_i   = 1'b0;
    hif.s_data_i    = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_init");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_cmd_ready", hif.cmd_ready_o, 1'b1);
    chk("idle_busy", busy_o, 1'b0);

    run_op(2'b01, FIPS_PT, '0, 0);          // no key yet -> error
    run_op(2'b00, FIPS_KEY, '0, 0);
    run_op(2'b01, FIPS_PT, FIPS_CT, 1);
    run_op(2'b10, FIPS_CT, FIPS_PT, 1);
    bp_mode = 1;
    run_op(2'b01, FIPS_PT, FIPS_CT, 1);
    bp_mode = 0;
    run_op(2'b11, FIPS_PT, '0, 0);          // reserved -> error

    stall_en = 1;
    gaps_en  = 1;
    for (int t = 0; t < 40; t++) begin
      rblk = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 9))
        0, 1:    rop = 2'b00;
        2, 3, 4: rop = 2'b01;
        5, 6, 7: rop = 2'b10;
        default: rop = 2'b11;
      endcase
      run_op(rop, rblk, '0, 0);
    end
    stall_en = 0;
    gaps_en  = 0;

    // Reset while the core is working.
    lat_fixed = 40;
    core_lat  = 40;
    rblk      = {$urandom, $urandom, $urandom, $urandom};
    exp_block = rblk;
    exp_op    = 2'b01;
    l0        = n_enc;
    send_cmd(2'b01);
    send_block(rblk);
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = (n_enc != l0);
    end
    if (!ok) begin
      fail("reset_issue");
      finish_now();
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    key_m     = 0;
    lat_fixed = -1;
    run_op(2'b01, rblk, '0, 0);             // key cleared by reset -> error

`ifdef AES_CTRL_TIMEOUT_EN
    run_op(2'b00, FIPS_KEY, '0, 0);
    core_mute = 1'b1;
    core_lat  = 2;
    exp_block = FIPS_PT;
    exp_op    = 2'b01;
    e0        = n_err;
    send_cmd(2'b01);
    send_block(FIPS_PT);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (n_err != e0);
    end
    if (!ok) fail("tmo_err");
    chk("tmo_err_delay", err_cyc - start_cyc, TMO + 1);
    @(negedge clk);
    chk("tmo_idle", busy_o, 1'b0);
    chk("tmo_no_words", exp_q.size(), 0);
    core_mute = 1'b0;
`endif

    repeat (3) @(posedge clk);
    finish_now();
  end

endmodule

// File: doc/aes128_host_ctrl.md
Name: aes128_host_ctrl

Overview:
- Initiator-side front end for the AES-128 core; the core is the responder.
- Accepts a command opcode, then four 32-bit data words from a word stream, and packs them into 128 bits.
- Drives the core's load-key / start-encrypt / start-decrypt pulses and captures the 128-bit result on the core's done cycle.
- Streams the result back out as four 32-bit words with valid/ready back-pressure.

Parameters:
- TIMEOUT_CYCLES, 255, maximum WAIT_DONE cycles before abort; used only when AES_CTRL_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted; high only in IDLE
- cmd_op_i  in  2  00 LOAD_KEY, 01 ENC, 10 DEC, 11 reserved
- s_valid_i  in  1  input word valid
- s_ready_o  out  1  input word accepted; high only in COLLECT
- s_data_i  in  32  input word
- m_valid_o  out  1  result word valid
- m_ready_i  in  1  result word taken
- m_data_o  out  32  result word
- m_last_o  out  1  fourth result word
- busy_o  out  1  state != IDLE
- err_o  out  1  one-cycle error pulse
- key_loaded_o  out  1  a key has been loaded since reset
- aes_load_key_o  out  1  load-key pulse to core
- aes_start_enc_o  out  1  start-encrypt pulse to core
- aes_start_dec_o  out  1  start-decrypt pulse to core
- aes_data_o  out  128  key/text to core, driven from the pack buffer
- aes_data_i  in  128  core result; valid only while aes_done_i is high
- aes_ready_i  in  1  core idle
- aes_done_i  in  1  core result valid this cycle

Behaviour:
- Reset: state IDLE; all outputs 0; buffer, word counter, key_loaded and opcode register cleared.
- Word order is big-endian: the first word maps to bits [127:96], the last to [31:0]. Output uses the same order.
- IDLE:
  - cmd_ready_o=1. On cmd_valid_i, latch op.
  - ENC or DEC with key_loaded=0, or op 11: err_o pulses next cycle and state stays IDLE. No data words are consumed.
  - Otherwise go to COLLECT with cnt=0.
- COLLECT:
  - s_ready_o=1. Each s_valid_i writes word cnt and increments cnt.
  - On the 4th word, go to ISSUE.
- ISSUE:
  - While aes_ready_i=0, wait.
  - When aes_ready_i=1, assert exactly one of the pulses, combinationally decoded from (state==ISSUE && aes_ready_i && op), for exactly 1 cycle.
  - LOAD_KEY: set key_loaded and go to IDLE; no output words.
  - ENC/DEC: go to WAIT_DONE.
- WAIT_DONE:
  - On aes_done_i, buffer <= aes_data_i, cnt=0, go to DRAIN.
  - A done pulse arriving on the first WAIT_DONE cycle is captured normally.
- DRAIN:
  - m_valid_o=1, m_data_o=word cnt, m_last_o=(cnt==3).
  - cnt advances only on m_ready_i. m_data_o holds stable under back-pressure.
  - After the last word is taken, go to IDLE.
- Total latency with no back-pressure: command (1) + 4 input words + ISSUE (1) + core latency + 4 output words.
- No pipelining: a new command is accepted only after DRAIN completes.
- aes_data_o is held constant from ISSUE through WAIT_DONE.
- Reset mid-operation: immediate return to reset values, no pulses. The core shares rst_n, so its key is also cleared.
- cnt is 2 bits and never wraps within a phase; the phase transition happens at cnt==3.

Optional Feature:
- Macro AES_CTRL_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT_DONE and increments each cycle.
  - If it reaches TIMEOUT_CYCLES without aes_done_i, err_o pulses and state returns to IDLE with no output words.
  - aes_done_i on the same cycle as expiry wins: the result is captured.
- Undefined: no counter; WAIT_DONE waits indefinitely.

Decomposition:
- Package aes_ctrl_pkg holds:
  - op enum aes_op_t (LOAD_KEY, ENC, DEC, RSVD)
  - state enum (IDLE, COLLECT, ISSUE, WAIT_DONE, DRAIN)
  - WORDS_PER_BLOCK=4
  - WORD_W=32
- No sub-module: the pack buffer and counter are inline.
- The bench instantiates this block together with the AES core.

Test Plan:
- LOAD_KEY with words 00010203, 04050607, 08090a0b, 0c0d0e0f -> exactly one aes_load_key_o pulse with aes_data_o=000102030405060708090a0b0c0d0e0f; key_loaded_o=1; no m_valid_o.
- ENC with 00112233, 44556677, 8899aabb, ccddeeff -> m_data_o sequence 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, with m_last_o on the 4th word.
- DEC with the ciphertext words above -> 00112233, 44556677, 8899aabb, ccddeeff.
- ENC immediately after reset (no key) -> err_o single pulse; s_ready_o never asserted; state IDLE.
- Back-pressure: m_ready_i low for 5 cycles on each output word -> m_data_o stable and no word lost or duplicated. rst_n asserted during WAIT_DONE -> all outputs 0 and key_loaded_o=0.
- With AES_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8, core done_i held low -> err_o pulse exactly 8 cycles after WAIT_DONE entry, then IDLE.
